// File: rtl/lru_matrix_ctrl.sv
// Matrix-LRU replacement controller: owns the read-modify-write of per-set
// LRU matrices in a 1-cycle-latency BRAM and self-initialises after reset.
module lru_matrix_ctrl #(
   parameter int WAYS         = 4,
   parameter int SETS         = 8,
   parameter int WAY_BITS     = $clog2(WAYS),
   parameter int SET_BITS     = $clog2(SETS),
   parameter int MATRIX_WIDTH = WAYS * WAYS
) (
   input  logic                    aclk_i,
   input  logic                    arst_i,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic                    req_op_i,
   input  logic [SET_BITS-1:0]     req_set_i,
   input  logic [WAY_BITS-1:0]     req_way_i,
   output logic                    resp_valid_o,
   input  logic                    resp_ready_i,
   output logic [WAY_BITS-1:0]     resp_way_o,
   output logic                    err_o,
   output logic                    init_done_o,
   output logic [SET_BITS-1:0]     matrix_addr_o,
   input  logic [MATRIX_WIDTH-1:0] matrix_vec_i,
   output logic                    write_vec_o,
   output logic [MATRIX_WIDTH-1:0] updated_matrix_vec_o
);

   typedef enum logic [2:0] {INIT, IDLE, RD, UPD, RESP} state_t;

   function automatic logic [MATRIX_WIDTH-1:0] init_vec();
      logic [MATRIX_WIDTH-1:0] v;
      v = '0;
      for (int i = 0; i < WAYS; i++)
         for (int j = 0; j < WAYS; j++)
            if (i > j) v[i*WAYS+j] = 1'b1;
      return v;
   endfunction

   localparam logic [MATRIX_WIDTH-1:0] INIT_VEC = init_vec();
   localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(SETS - 1);
   localparam logic [WAY_BITS:0] WAYS_LIM = (WAY_BITS+1)'(WAYS);

   state_t                    state;
   logic [SET_BITS-1:0]       init_cnt;
   logic [SET_BITS-1:0]       addr_q;
   logic                      write_q;
   logic                      op_q;
   logic [WAY_BITS-1:0]       way_q;
   logic                      ready_q;
   logic                      resp_valid_q;
   logic [WAY_BITS-1:0]       resp_way_q;
   logic                      err_q;
   logic                      done_q;

   logic [WAY_BITS-1:0]       victim;
   logic                      row_zero;
   logic [WAY_BITS-1:0]       tgt;
   logic [MATRIX_WIDTH-1:0]   upd_vec;
   logic                      bad_way;

   // Scan downwards so the lowest qualifying row wins; none -> way 0.
   always_comb begin
      victim   = '0;
      row_zero = 1'b0;
      for (int i = WAYS - 1; i >= 0; i--) begin
         row_zero = 1'b1;
         for (int j = 0; j < WAYS; j++)
            if (j != i && matrix_vec_i[i*WAYS+j]) row_zero = 1'b0;
         if (row_zero) victim = WAY_BITS'(i);
      end
   end

   always_comb begin
      tgt     = op_q ? victim : way_q;
      upd_vec = '0;
      for (int i = 0; i < WAYS; i++)
         for (int j = 0; j < WAYS; j++)
            if (i == j)
               upd_vec[i*WAYS+j] = 1'b0;
            else if (i == int'(tgt))
               upd_vec[i*WAYS+j] = 1'b1;
            else if (j == int'(tgt))
               upd_vec[i*WAYS+j] = 1'b0;
            else
               upd_vec[i*WAYS+j] = matrix_vec_i[i*WAYS+j];
   end

   assign bad_way = !req_op_i && ({1'b0, req_way_i} >= WAYS_LIM);

   // During reset the BRAM port shows the INIT write, so an UPD write is dropped.
   assign matrix_addr_o        = arst_i ? '0 : addr_q;
   assign write_vec_o          = arst_i | write_q;
   assign updated_matrix_vec_o = (state == UPD && !arst_i) ? upd_vec : INIT_VEC;

   assign req_ready_o  = ready_q;
   assign resp_valid_o = resp_valid_q;
   assign resp_way_o   = resp_way_q;
   assign err_o        = err_q;
   assign init_done_o  = done_q;

   always_ff @(posedge aclk_i) begin
      if (arst_i) begin
         state        <= INIT;
         init_cnt     <= '0;
         addr_q       <= '0;
         write_q      <= 1'b1;
         op_q         <= 1'b0;
         way_q        <= '0;
         ready_q      <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_way_q   <= '0;
         err_q        <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         err_q <= 1'b0;
         unique case (state)
            INIT: begin
               if (init_cnt == LAST_SET) begin
                  state   <= IDLE;
                  write_q <= 1'b0;
                  ready_q <= 1'b1;
                  done_q  <= 1'b1;
               end else begin
                  init_cnt <= init_cnt + 1'b1;
                  addr_q   <= init_cnt + 1'b1;
               end
            end
            IDLE: begin
               if (req_valid_i && ready_q) begin
                  op_q  <= req_op_i;
                  way_q <= req_way_i;
                  if (bad_way) begin
                     err_q <= 1'b1;
                  end else begin
                     state   <= RD;
                     ready_q <= 1'b0;
                     addr_q  <= req_set_i;
                  end
               end
            end
            RD: begin
               state   <= UPD;
               write_q <= 1'b1;
            end
            UPD: begin
               write_q <= 1'b0;
               if (op_q) begin
                  resp_way_q   <= victim;
                  resp_valid_q <= 1'b1;
                  state        <= RESP;
               end else begin
                  ready_q <= 1'b1;
                  state   <= IDLE;
               end
            end
            RESP: begin
               if (resp_ready_i) begin
                  resp_valid_q <= 1'b0;
                  ready_q      <= 1'b1;
                  state        <= IDLE;
               end
            end
            default: state <= INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_lru_matrix_ctrl.sv
// Directed bench for lru_matrix_ctrl: a 4-way and a 6-way instance,
// each with a behavioural 1-cycle-latency BRAM.
module tb_lru_matrix_ctrl;

   logic        clk = 1'b0;
   logic        arst;

   logic        req_valid, req_ready, req_op;
   logic [2:0]  req_set;
   logic [1:0]  req_way;
   logic        resp_valid, resp_ready;
   logic [1:0]  resp_way;
   logic        err, init_done;
   logic [2:0]  maddr;
   logic [15:0] mrd, mwr;
   logic        mwe;

   logic        v6, rdy6, op6;
   logic [2:0]  set6;
   logic [2:0]  way6;
   logic        rv6, rr6;
   logic [2:0]  rw6;
   logic        err6, done6;
   logic [2:0]  maddr6;
   logic [35:0] mrd6, mwr6;
   logic        mwe6;

   logic [15:0] mem4 [8];
   logic [35:0] mem6 [8];

   int tests  = 0;
   int failed = 0;

   localparam logic [15:0] IV4 = 16'h7310;

   always #5 clk = ~clk;

   lru_matrix_ctrl #(.WAYS(4), .SETS(8)) dut (
      .aclk_i(clk), .arst_i(arst),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_op_i(req_op), .req_set_i(req_set), .req_way_i(req_way),
      .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
      .resp_way_o(resp_way), .err_o(err), .init_done_o(init_done),
      .matrix_addr_o(maddr), .matrix_vec_i(mrd),
      .write_vec_o(mwe), .updated_matrix_vec_o(mwr)
   );

   lru_matrix_ctrl #(.WAYS(6), .SETS(8)) dut6 (
      .aclk_i(clk), .arst_i(arst),
      .req_valid_i(v6), .req_ready_o(rdy6),
      .req_op_i(op6), .req_set_i(set6), .req_way_i(way6),
      .resp_valid_o(rv6), .resp_ready_i(rr6),
      .resp_way_o(rw6), .err_o(err6), .init_done_o(done6),
      .matrix_addr_o(maddr6), .matrix_vec_i(mrd6),
      .write_vec_o(mwe6), .updated_matrix_vec_o(mwr6)
   );

   always @(posedge clk) begin
      if (mwe) mem4[maddr] <= mwr;
      mrd <= mem4[maddr];
      if (mwe6) mem6[maddr6] <= mwr6;
      mrd6 <= mem6[maddr6];
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", 64'(n < 20), 64'd1);
   endtask

   task automatic sweep(input string tag);
      for (int k = 0; k < 8; k++) begin
         chk({tag, "_addr"}, 64'(maddr), 64'(k));
         chk({tag, "_we"}, 64'(mwe), 64'd1);
         chk({tag, "_done_lo"}, 64'(init_done), 64'd0);
         @(negedge clk);
      end
      chk({tag, "_done"}, 64'(init_done), 64'd1);
      chk({tag, "_ready"}, 64'(req_ready), 64'd1);
      chk({tag, "_we_off"}, 64'(mwe), 64'd0);
      for (int s = 0; s < 8; s++)
         chk({tag, "_mem"}, 64'(mem4[s]), 64'(IV4));
   endtask

   task automatic alloc(input logic [2:0] s, input logic [1:0] exp,
                        input int hold, input string tag);
      wait_ready();
      req_valid = 1'b1;
      req_op    = 1'b1;
      req_set   = s;
      req_way   = 2'd3;
      @(negedge clk);
      req_valid = 1'b0;
      chk({tag, "_rd_we"}, 64'(mwe), 64'd0);
      chk({tag, "_rd_addr"}, 64'(maddr), 64'(s));
      if (hold > 0) resp_ready = 1'b0;
      @(negedge clk);
      chk({tag, "_upd_we"}, 64'(mwe), 64'd1);
      chk({tag, "_upd_addr"}, 64'(maddr), 64'(s));
      @(negedge clk);
      chk({tag, "_valid"}, 64'(resp_valid), 64'd1);
      chk({tag, "_way"}, 64'(resp_way), 64'(exp));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({tag, "_hold_valid"}, 64'(resp_valid), 64'd1);
         chk({tag, "_hold_way"}, 64'(resp_way), 64'(exp));
         chk({tag, "_hold_ready"}, 64'(req_ready), 64'd0);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      chk({tag, "_valid_lo"}, 64'(resp_valid), 64'd0);
      chk({tag, "_idle"}, 64'(req_ready), 64'd1);
   endtask

   task automatic touch(input logic [2:0] s, input logic [1:0] w,
                        input logic [15:0] expvec, input string tag);
      wait_ready();
      req_valid = 1'b1;
      req_op    = 1'b0;
      req_set   = s;
      req_way   = w;
      @(negedge clk);
      req_valid = 1'b0;
      chk({tag, "_rd_we"}, 64'(mwe), 64'd0);
      @(negedge clk);
      chk({tag, "_upd_we"}, 64'(mwe), 64'd1);
      chk({tag, "_upd_vec"}, 64'(mwr), 64'(expvec));
      @(negedge clk);
      chk({tag, "_idle"}, 64'(req_ready), 64'd1);
      chk({tag, "_no_resp"}, 64'(resp_valid), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      req_valid = 0; req_op = 0; req_set = 0; req_way = 0; resp_ready = 1;
      v6 = 0; op6 = 0; set6 = 0; way6 = 0; rr6 = 1;
      arst = 1'b1;
      repeat (5) @(negedge clk);

      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_resp_way", 64'(resp_way), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_done", 64'(init_done), 64'd0);
      chk("rst_we", 64'(mwe), 64'd1);
      chk("rst_addr", 64'(maddr), 64'd0);
      chk("rst_vec", 64'(mwr), 64'(IV4));
      chk("rst_vec6", 64'(mwr6), 64'h7_CF1C_3040);

      arst = 1'b0;
      #1;
      sweep("init");
      chk("init_done6", 64'(done6), 64'd1);

      alloc(3'd3, 2'd0, 0, "t1");

      alloc(3'd3, 2'd1, 0, "t2a");
      alloc(3'd3, 2'd2, 0, "t2b");
      alloc(3'd3, 2'd3, 0, "t2c");
      alloc(3'd3, 2'd0, 0, "t2d");

      touch(3'd5, 2'd0, 16'h620E, "t3_touch");
      chk("t3_mem", 64'(mem4[5]), 64'h620E);
      alloc(3'd5, 2'd1, 0, "t3a");
      alloc(3'd4, 2'd0, 0, "t3b");

      alloc(3'd6, 2'd0, 5, "t4");

      chk("t5_ready", 64'(rdy6), 64'd1);
      v6 = 1'b1; op6 = 1'b0; set6 = 3'd1; way6 = 3'd7;
      @(negedge clk);
      v6 = 1'b0;
      chk("t5_err", 64'(err6), 64'd1);
      chk("t5_we", 64'(mwe6), 64'd0);
      chk("t5_still_idle", 64'(rdy6), 64'd1);
      @(negedge clk);
      chk("t5_err_pulse", 64'(err6), 64'd0);
      chk("t5_we2", 64'(mwe6), 64'd0);
      v6 = 1'b1; op6 = 1'b1; set6 = 3'd1; way6 = 3'd0;
      @(negedge clk);
      v6 = 1'b0;
      chk("t5_rd_we", 64'(mwe6), 64'd0);
      @(negedge clk);
      chk("t5_upd_we", 64'(mwe6), 64'd1);
      @(negedge clk);
      chk("t5_valid", 64'(rv6), 64'd1);
      chk("t5_way", 64'(rw6), 64'd0);
      @(negedge clk);
      chk("t5_valid_lo", 64'(rv6), 64'd0);

      wait_ready();
      req_valid = 1'b1; req_op = 1'b1; req_set = 3'd2; req_way = 2'd0;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      chk("t6_upd_we", 64'(mwe), 64'd1);
      chk("t6_upd_addr", 64'(maddr), 64'd2);
      arst = 1'b1;
      #1;
      chk("t6_rst_we", 64'(mwe), 64'd1);
      chk("t6_rst_addr", 64'(maddr), 64'd0);
      chk("t6_rst_vec", 64'(mwr), 64'(IV4));
      @(negedge clk);
      chk("t6_no_resp", 64'(resp_valid), 64'd0);
      chk("t6_ready_lo", 64'(req_ready), 64'd0);
      chk("t6_done_lo", 64'(init_done), 64'd0);
      arst = 1'b0;
      #1;
      sweep("t6_init");
      alloc(3'd2, 2'd0, 0, "t6");

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
